rmii_rx_framer: RTL and testbench

Receive-side framer between the RMII PHY pins and the receive packet buffer of the Ethernet module, in the 50 MHz RMII clock domain. It strips preamble/SFD, filters on destination MAC, captures EtherType, packs payload bytes into 32-bit words, withholds the trailing FCS, checks CRC-32, and reports per-frame status. The buffer stage downstream exposes these words and counts over AXI as RX data, data count and protocol type.

---
 rtl/eth_pkg.sv | 53 +++++
 rtl/rmii_rx_framer_if.sv | 26 ++
 rtl/eth_crc32_d8.sv | 31 +++
 rtl/rmii_rx_framer.sv | 229 ++++++++++++++++++++++
 tb/tb_rmii_rx_framer.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/eth_pkg.sv
// Shared types and constants for the RMII receive framer: FSM states, RMII
// line symbols, CRC-32 parameters and the err_flags layout.
package eth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_DATA     = 3'd2,
    ST_DROP     = 3'd3,
    ST_DONE     = 3'd4
  } rx_state_e;

  localparam logic [1:0]  PREAMBLE_DIBIT = 2'b01;
  localparam logic [1:0]  SFD_DIBIT      = 2'b11;
  localparam logic [31:0] CRC_INIT       = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RESIDUE    = 32'hDEBB_20E3;
  localparam logic [31:0] CRC_POLY_REFL  = 32'hEDB8_8320;
  localparam logic [47:0] BCAST_MAC      = 48'hFFFF_FFFF_FFFF;

  localparam int ERR_RX_ER    = 0;
  localparam int ERR_OVERFLOW = 1;
  localparam int ERR_RUNT     = 2;
  localparam int ERR_CRC      = 3;

  // Reflected CRC-32 (0x04C11DB7) folded over one byte, LSB first.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in, input logic [7:0] data);
    logic [31:0] c;
    c = crc_in ^ {24'h00_0000, data};
    for (int i = 0; i < 8; i++) begin
      if (c[0]) begin
        c = (c >> 1) ^ CRC_POLY_REFL;
      end else begin
        c = c >> 1;
      end
    end
    return c;
  endfunction

  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
    logic [7:0] b;
    case (idx)
      3'd0:    b = mac[47:40];
      3'd1:    b = mac[39:32];
      3'd2:    b = mac[31:24];
      3'd3:    b = mac[23:16];
      3'd4:    b = mac[15:8];
      3'd5:    b = mac[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/rmii_rx_framer_if.sv
// RMII receive pins plus the framer's word/status bus toward the packet buffer.
interface rmii_rx_framer_if;
  logic        crs_dv;
  logic [1:0]  rx_d;
  logic        rx_er;
  logic [31:0] word_data;
  logic        word_valid;
  logic        frame_done;
  logic        frame_ok;
  logic [3:0]  err_flags;
  logic [15:0] byte_count;
  logic [15:0] protocol_type;
  logic        rx_busy;

  modport master (
    input  crs_dv, rx_d, rx_er,
    output word_data, word_valid, frame_done, frame_ok, err_flags,
           byte_count, protocol_type, rx_busy
  );

  modport slave (
    output crs_dv, rx_d, rx_er,
    input  word_data, word_valid, frame_done, frame_ok, err_flags,
           byte_count, protocol_type, rx_busy
  );
endinterface

// File: rtl/eth_crc32_d8.sv
// Registered byte-wide CRC-32 accumulator; the register is left unreflected
// and uninverted so a good frame leaves the fixed residue behind.
module eth_crc32_d8
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  logic [31:0] crc_r;

  // Load the seed on init, otherwise fold in one byte per enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_r <= CRC_INIT;
    end else if (init) begin
      crc_r <= CRC_INIT;
    end else if (en) begin
      crc_r <= crc32_byte(crc_r, data);
    end else begin
      crc_r <= crc_r;
    end
  end

  assign crc = crc_r;

endmodule

// File: rtl/rmii_rx_framer.sv
// RMII receive framer: preamble/SFD strip, destination filter, EtherType
// capture, FCS-withholding payload packer, CRC check and frame status.
module rmii_rx_framer
  import eth_pkg::*;
#(
  parameter logic [47:0] MAC_ADDR  = 48'h02_00_00_00_00_01,
  parameter int unsigned MAX_BYTES = 1518,
  parameter int unsigned MIN_BYTES = 64
) (
  input  logic             clk_50_mhz,
  input  logic             rst,
  rmii_rx_framer_if.master bus
);

  localparam logic [15:0] MAX_TOTAL   = 16'(MAX_BYTES);
  localparam logic [15:0] MIN_TOTAL   = 16'(MIN_BYTES);
  localparam logic [15:0] MAX_PAYLOAD = 16'(MAX_BYTES - 32'd18);

  rx_state_e   state_r;
  logic [5:0]  sr_r;
  logic [1:0]  dibit_cnt_r;
  logic [15:0] byte_idx_r;
  logic        zero_r;
  logic        dest_me_r;
  logic        dest_bc_r;
  logic [31:0] dly_r;
  logic [2:0]  dly_cnt_r;
  logic [23:0] pack_r;
  logic [1:0]  pack_cnt_r;
  logic        er_r;
  logic [31:0] word_data_r;
  logic        word_valid_r;
  logic        frame_done_r;
  logic        frame_ok_r;
  logic [3:0]  err_flags_r;
  logic [15:0] byte_count_r;
  logic [15:0] proto_r;
  logic        rx_busy_r;

  logic [7:0]  byte_s;
  logic        byte_done_s;
  logic        me_ok_s;
  logic        bc_ok_s;
  logic        end_s;
  logic        payload_s;
  logic        emit_s;
  logic        crc_init_s;
  logic [31:0] crc_s;
  logic [3:0]  err_s;

  // Byte completion, destination match and end-of-frame decode for this clock.
  always_comb begin
    byte_s      = {bus.rx_d, sr_r};
    byte_done_s = (state_r == ST_DATA) && bus.crs_dv && (dibit_cnt_r == 2'd3);
    me_ok_s     = dest_me_r && (byte_s == mac_byte(MAC_ADDR, byte_idx_r[2:0]));
    bc_ok_s     = dest_bc_r && (byte_s == mac_byte(BCAST_MAC, byte_idx_r[2:0]));
    end_s       = (state_r == ST_DATA) && !bus.crs_dv && zero_r;
    payload_s   = byte_done_s && (byte_idx_r >= 16'd14);
    // Only bytes leaving a full delay line can be payload; the last four stay behind as FCS.
    emit_s      = payload_s && (dly_cnt_r == 3'd4) && (byte_count_r < MAX_PAYLOAD);
    crc_init_s  = (state_r == ST_PREAMBLE) && bus.crs_dv && (bus.rx_d == SFD_DIBIT);
    err_s       = 4'b0000;
    err_s[ERR_CRC]      = (crc_s != CRC_RESIDUE);
    err_s[ERR_RUNT]     = (byte_idx_r < MIN_TOTAL);
    err_s[ERR_OVERFLOW] = (byte_idx_r > MAX_TOTAL);
    err_s[ERR_RX_ER]    = er_r;
  end

  eth_crc32_d8 u_crc (
    .clk  (clk_50_mhz),
    .rst  (rst),
    .init (crc_init_s),
    .en   (byte_done_s),
    .data (byte_s),
    .crc  (crc_s)
  );

  // Frame state machine with byte assembly, delay line, packer and status registers.
  always_ff @(posedge clk_50_mhz) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      sr_r         <= 6'd0;
      dibit_cnt_r  <= 2'd0;
      byte_idx_r   <= 16'd0;
      zero_r       <= 1'b0;
      dest_me_r    <= 1'b0;
      dest_bc_r    <= 1'b0;
      dly_r        <= 32'd0;
      dly_cnt_r    <= 3'd0;
      pack_r       <= 24'd0;
      pack_cnt_r   <= 2'd0;
      er_r         <= 1'b0;
      word_data_r  <= 32'd0;
      word_valid_r <= 1'b0;
      frame_done_r <= 1'b0;
      frame_ok_r   <= 1'b0;
      err_flags_r  <= 4'd0;
      byte_count_r <= 16'd0;
      proto_r      <= 16'd0;
      rx_busy_r    <= 1'b0;
    end else begin
      word_valid_r <= 1'b0;
      frame_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (bus.crs_dv && (bus.rx_d == PREAMBLE_DIBIT)) begin
            state_r <= ST_PREAMBLE;
          end
        end
        ST_PREAMBLE: begin
          if (crc_init_s) begin
            state_r      <= ST_DATA;
            dibit_cnt_r  <= 2'd0;
            byte_idx_r   <= 16'd0;
            zero_r       <= 1'b0;
            dest_me_r    <= 1'b1;
            dest_bc_r    <= 1'b1;
            dly_cnt_r    <= 3'd0;
            pack_cnt_r   <= 2'd0;
            er_r         <= 1'b0;
            byte_count_r <= 16'd0;
            frame_ok_r   <= 1'b0;
            err_flags_r  <= 4'd0;
            rx_busy_r    <= 1'b1;
          end else if (!(bus.crs_dv && (bus.rx_d == PREAMBLE_DIBIT))) begin
            state_r <= ST_IDLE;
          end
        end
        ST_DATA: begin
          er_r <= er_r | bus.rx_er;
          if (bus.crs_dv) begin
            zero_r      <= 1'b0;
            sr_r        <= {bus.rx_d, sr_r[5:2]};
            dibit_cnt_r <= dibit_cnt_r + 2'd1;
          end else begin
            zero_r <= 1'b1;
          end
          if (byte_done_s) begin
            if (byte_idx_r != 16'hFFFF) begin
              byte_idx_r <= byte_idx_r + 16'd1;
            end
            if (byte_idx_r < 16'd6) begin
              dest_me_r <= me_ok_s;
              dest_bc_r <= bc_ok_s;
            end
            if (byte_idx_r == 16'd12) begin
              proto_r[15:8] <= byte_s;
            end
            if (byte_idx_r == 16'd13) begin
              proto_r[7:0] <= byte_s;
            end
            if (payload_s) begin
              dly_r <= {dly_r[23:0], byte_s};
              if (dly_cnt_r != 3'd4) begin
                dly_cnt_r <= dly_cnt_r + 3'd1;
              end
            end
            if (emit_s) begin
              byte_count_r <= byte_count_r + 16'd1;
              pack_cnt_r   <= pack_cnt_r + 2'd1;
              case (pack_cnt_r)
                2'd0: pack_r[7:0]   <= dly_r[31:24];
                2'd1: pack_r[15:8]  <= dly_r[31:24];
                2'd2: pack_r[23:16] <= dly_r[31:24];
                2'd3: begin
                  word_data_r  <= {dly_r[31:24], pack_r};
                  word_valid_r <= 1'b1;
                end
                default: pack_r <= pack_r;
              endcase
            end
          end
          if (byte_done_s && (byte_idx_r == 16'd5) && !me_ok_s && !bc_ok_s) begin
            state_r <= ST_DROP;
          end else if (end_s) begin
            state_r <= ST_DONE;
            // Flush the partial word with its unused upper bytes zeroed.
            case (pack_cnt_r)
              2'd1: begin
                word_data_r  <= {24'd0, pack_r[7:0]};
                word_valid_r <= 1'b1;
              end
              2'd2: begin
                word_data_r  <= {16'd0, pack_r[15:0]};
                word_valid_r <= 1'b1;
              end
              2'd3: begin
                word_data_r  <= {8'd0, pack_r};
                word_valid_r <= 1'b1;
              end
              default: word_valid_r <= 1'b0;
            endcase
          end
        end
        ST_DROP: begin
          if (bus.crs_dv) begin
            zero_r <= 1'b0;
          end else if (zero_r) begin
            state_r   <= ST_IDLE;
            rx_busy_r <= 1'b0;
          end else begin
            zero_r <= 1'b1;
          end
        end
        ST_DONE: begin
          frame_done_r <= 1'b1;
          rx_busy_r    <= 1'b0;
          err_flags_r  <= err_s;
          frame_ok_r   <= (err_s == 4'd0);
          state_r      <= ST_IDLE;
        end
        default: begin
          state_r   <= ST_IDLE;
          rx_busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.word_data     = word_data_r;
  assign bus.word_valid    = word_valid_r;
  assign bus.frame_done    = frame_done_r;
  assign bus.frame_ok      = frame_ok_r;
  assign bus.err_flags     = err_flags_r;
  assign bus.byte_count    = byte_count_r;
  assign bus.protocol_type = proto_r;
  assign bus.rx_busy       = rx_busy_r;

endmodule

// File: tb/tb_rmii_rx_framer.sv
// Self-checking bench for rmii_rx_framer: directed and random frames checked
// against a byte-level reference model of the framer's rules.
module tb_rmii_rx_framer;

  localparam logic [47:0] STA_MAC = 48'h02_00_00_00_00_01;

  logic clk_50_mhz = 1'b0;
  logic rst = 1'b1;
  always #10 clk_50_mhz = ~clk_50_mhz;

  rmii_rx_framer_if bus ();

  rmii_rx_framer #(
    .MAC_ADDR  (STA_MAC),
    .MAX_BYTES (1518),
    .MIN_BYTES (64)
  ) dut (
    .clk_50_mhz (clk_50_mhz),
    .rst        (rst),
    .bus        (bus)
  );

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge.
  logic [31:0] got_words[$];
  int          done_cnt = 0;
  int          wv_at_done = 0;
  int          busy_at_done = 0;
  logic        cap_ok;
  logic [3:0]  cap_err;
  logic [15:0] cap_bc;
  logic [15:0] cap_pt;

  always @(negedge clk_50_mhz) begin
    if (bus.word_valid) got_words.push_back(bus.word_data);
    if (bus.frame_done) begin
      done_cnt++;
      cap_ok  = bus.frame_ok;
      cap_err = bus.err_flags;
      cap_bc  = bus.byte_count;
      cap_pt  = bus.protocol_type;
      if (bus.word_valid) wv_at_done++;
      if (bus.rx_busy) busy_at_done++;
    end
  end

  function automatic logic [31:0] crc32_ref(input logic [7:0] f[$], input int n);
    logic [31:0] c;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'd0, f[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return ~c;
  endfunction

  // pmode 0: payload byte i = i; pmode 1: random payload.
  task automatic build_frame(input logic [47:0] dst, input logic [15:0] etype, input int total,
                             input int pmode, output logic [7:0] f[$]);
    logic [31:0] fcs;
    logic [47:0] src;
    src = 48'h02_11_22_33_44_55;
    f = {};
    for (int i = 0; i < 6; i++) f.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) f.push_back(src[47-8*i -: 8]);
    f.push_back(etype[15:8]);
    f.push_back(etype[7:0]);
    for (int i = 0; i < total - 18; i++) f.push_back(pmode == 0 ? 8'(i) : 8'($urandom_range(0, 255)));
    fcs = crc32_ref(f, f.size());
    for (int i = 0; i < 4; i++) f.push_back(fcs[8*i +: 8]);
  endtask

  task automatic drive(input logic dv, input logic [1:0] d, input logic er);
    bus.crs_dv = dv;
    bus.rx_d   = d;
    bus.rx_er  = er;
    @(posedge clk_50_mhz);
    #1;
  endtask

  // Sends preamble, SFD and bytes; rst_byte >= 0 aborts with a reset there.
  task automatic send_frame(input logic [7:0] f[$], input int er_byte, input int rst_byte);
    logic [7:0] b;
    for (int i = 0; i < 32; i++) drive(1'b1, (i == 31) ? 2'b11 : 2'b01, 1'b0);
    for (int n = 0; n < f.size(); n++) begin
      if (n == rst_byte) begin
        bus.crs_dv = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk_50_mhz);
        #1;
        rst = 1'b0;
        return;
      end
      b = f[n];
      for (int k = 0; k < 4; k++) drive(1'b1, b[2*k +: 2], (n == er_byte) ? 1'b1 : 1'b0);
    end
    repeat (8) drive(1'b0, 2'b00, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_wv"},    {31'd0, bus.word_valid}, 32'd0);
    check_val({tag, "_wd"},    bus.word_data, 32'd0);
    check_val({tag, "_done"},  {31'd0, bus.frame_done}, 32'd0);
    check_val({tag, "_ok"},    {31'd0, bus.frame_ok}, 32'd0);
    check_val({tag, "_err"},   {28'd0, bus.err_flags}, 32'd0);
    check_val({tag, "_bc"},    {16'd0, bus.byte_count}, 32'd0);
    check_val({tag, "_pt"},    {16'd0, bus.protocol_type}, 32'd0);
    check_val({tag, "_busy"},  {31'd0, bus.rx_busy}, 32'd0);
  endtask

  // Sends f and checks every observable against the reference model.
  task automatic run_frame(input string tag, input logic [7:0] f[$], input int er_byte);
    logic [31:0] ew[$];
    logic [31:0] w;
    logic [31:0] fcs_rx;
    logic [3:0]  eerr;
    int          total, eff;
    logic        accept;
    total  = f.size();
    accept = ({f[0], f[1], f[2], f[3], f[4], f[5]} == STA_MAC) ||
             ({f[0], f[1], f[2], f[3], f[4], f[5]} == 48'hFFFF_FFFF_FFFF);
    eff = (total - 18 > 1500) ? 1500 : total - 18;
    w = 32'd0;
    for (int i = 0; i < eff; i++) begin
      if (i % 4 == 0) w = 32'd0;
      w[8*(i%4) +: 8] = f[14+i];
      if ((i % 4 == 3) || (i == eff - 1)) ew.push_back(w);
    end
    fcs_rx = {f[total-1], f[total-2], f[total-3], f[total-4]};
    eerr = {crc32_ref(f, total - 4) != fcs_rx, total < 64, total > 1518, er_byte >= 0};

    got_words = {};
    done_cnt = 0;
    wv_at_done = 0;
    busy_at_done = 0;
    send_frame(f, er_byte, -1);

    if (accept) begin
      check_val({tag, "_done_cnt"}, done_cnt, 32'd1);
      check_val({tag, "_nwords"}, got_words.size(), ew.size());
      for (int i = 0; i < ew.size(); i++)
        check_val($sformatf("%s_word%0d", tag, i), (i < got_words.size()) ? got_words[i] : 32'hxxxx_xxxx, ew[i]);
      check_val({tag, "_ok"}, {31'd0, cap_ok}, {31'd0, eerr == 4'd0});
      check_val({tag, "_err"}, {28'd0, cap_err}, {28'd0, eerr});
      check_val({tag, "_bc"}, {16'd0, cap_bc}, eff);
      check_val({tag, "_pt"}, {16'd0, cap_pt}, {16'd0, f[12], f[13]});
      check_val({tag, "_wv_at_done"}, wv_at_done, 32'd0);
      check_val({tag, "_busy_at_done"}, busy_at_done, 32'd0);
    end else begin
      check_val({tag, "_drop_done"}, done_cnt, 32'd0);
      check_val({tag, "_drop_words"}, got_words.size(), 32'd0);
    end
    check_val({tag, "_busy_after"}, {31'd0, bus.rx_busy}, 32'd0);
  endtask

  initial begin
    logic [7:0]  f[$];
    logic [47:0] dst;
    int          total, er_byte, pick;
    bus.crs_dv = 1'b0;
    bus.rx_d   = 2'b00;
    bus.rx_er  = 1'b0;
    repeat (4) @(posedge clk_50_mhz);
    #1;
    rst = 1'b0;
    drive(1'b0, 2'b00, 1'b0);
    check_reset_outputs("reset");

    // Nominal 64-byte frame with incrementing payload.
    build_frame(STA_MAC, 16'h0800, 64, 0, f);
    run_frame("good64", f, -1);
    check_val("good64_first", (got_words.size() > 0) ? got_words[0] : 32'hxxxx_xxxx, 32'h0302_0100);
    check_val("good64_last", (got_words.size() > 0) ? got_words[got_words.size()-1] : 32'hxxxx_xxxx, 32'h0000_2D2C);

    // Same frame with one payload bit flipped.
    f[20] = f[20] ^ 8'h10;
    run_frame("crcbad", f, -1);
    check_val("crcbad_err", {28'd0, cap_err}, 32'h0000_0008);

    // Broadcast runt with a valid FCS.
    build_frame(48'hFFFF_FFFF_FFFF, 16'h0806, 60, 1, f);
    run_frame("runt", f, -1);
    check_val("runt_err", {28'd0, cap_err}, 32'h0000_0004);

    // Foreign destination is dropped, next good frame is received.
    build_frame(48'h02_00_00_00_00_02, 16'h0800, 80, 1, f);
    run_frame("drop", f, -1);
    build_frame(STA_MAC, 16'h86DD, 100, 1, f);
    run_frame("after_drop", f, -1);

    // rx_er during payload byte 20.
    build_frame(STA_MAC, 16'h0800, 90, 1, f);
    run_frame("rxer", f, 14 + 20);
    check_val("rxer_err", {28'd0, cap_err}, 32'h0000_0001);

    // Oversized frame saturates the byte count.
    build_frame(STA_MAC, 16'h0800, 1600, 1, f);
    run_frame("over", f, -1);
    check_val("over_bc", {16'd0, cap_bc}, 32'd1500);

    // Reset mid-payload abandons the frame.
    build_frame(STA_MAC, 16'h0800, 120, 1, f);
    got_words = {};
    done_cnt = 0;
    send_frame(f, -1, 30);
    drive(1'b0, 2'b00, 1'b0);
    check_reset_outputs("midrst");
    repeat (4) drive(1'b0, 2'b00, 1'b0);
    check_val("midrst_no_done", done_cnt, 32'd0);
    build_frame(STA_MAC, 16'h0800, 70, 1, f);
    run_frame("post_rst", f, -1);

    // Random frames: destination, length, corruption and rx_er vary.
    for (int t = 0; t < 12; t++) begin
      pick  = $urandom_range(0, 3);
      dst   = (pick == 0) ? 48'hFFFF_FFFF_FFFF : (pick == 1) ? 48'h02_00_00_00_00_02 : STA_MAC;
      total = $urandom_range(60, 200);
      build_frame(dst, 16'($urandom_range(0, 65535)), total, 1, f);
      if ($urandom_range(0, 3) == 0) f[$urandom_range(0, total - 1)] ^= 8'(1 << $urandom_range(0, 7));
      er_byte = ($urandom_range(0, 3) == 0) ? $urandom_range(14, total - 5) : -1;
      run_frame($sformatf("rnd%0d", t), f, er_byte);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
